// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: MDOp encodings, FSM states
// and default latencies.
package md_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_MADD  = 3'd7
  } md_op_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  localparam int MD_MUL_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF = 10;

endpackage

// File: rtl/md_unit.sv
// Multi-cycle MIPS multiply/divide unit holding architectural HI/LO.
// Optional feature: define MD_MADD_EN to enable madd (MDOp=7) accumulate.
module md_unit
  import md_pkg::*;
#(
  parameter int MUL_CYCLES = MD_MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = MD_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  MDOp,
  input  logic        start,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  // Divisor 1 stands in for a zero divisor (result discarded) and for the
  // signed INT_MIN / -1 case, where A / 1 already yields LO=A, HI=0.
  function automatic logic [31:0] safe_divisor(input logic [31:0] a,
                                               input logic [31:0] b,
                                               input logic        is_signed);
    if (b == 32'd0)
      return 32'd1;
    if (is_signed && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF))
      return 32'd1;
    return b;
  endfunction

  md_state_e        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_hi, r_lo;
  logic [63:0]      r_res;
  logic             r_res_we;

  md_op_e w_op;
  logic   w_is_long, w_is_div, w_accept, w_idle_start, w_done;

  assign w_op = md_op_e'(MDOp);

  always_comb begin
    w_is_long = 1'b0;
    case (w_op)
      MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: w_is_long = 1'b1;
`ifdef MD_MADD_EN
      MD_MADD: w_is_long = 1'b1;
`endif
      default: w_is_long = 1'b0;
    endcase
  end

  assign w_is_div     = (w_op == MD_DIV) || (w_op == MD_DIVU);
  assign w_idle_start = start && (r_state == MD_IDLE);
  assign w_accept     = w_idle_start && w_is_long;
  assign w_done       = (r_state == MD_BUSY) && (r_cnt == CNT_W'(1));

  // Datapath: full results computed from the operands present at the start edge
  logic signed [63:0] w_a_sx, w_b_sx, w_prod_s;
  logic        [63:0] w_prod_u;
  logic signed [31:0] w_dvd_s, w_dvs_s, w_quo_s, w_rem_s;
  logic        [31:0] w_dvs_u, w_quo_u, w_rem_u;
  logic        [63:0] w_res;
  logic               w_res_we;

  assign w_a_sx   = {{32{A[31]}}, A};
  assign w_b_sx   = {{32{B[31]}}, B};
  assign w_prod_s = w_a_sx * w_b_sx;
  assign w_prod_u = {32'd0, A} * {32'd0, B};

  assign w_dvd_s  = A;
  assign w_dvs_s  = safe_divisor(A, B, 1'b1);
  assign w_quo_s  = w_dvd_s / w_dvs_s;
  assign w_rem_s  = w_dvd_s % w_dvs_s;

  assign w_dvs_u  = safe_divisor(A, B, 1'b0);
  assign w_quo_u  = A / w_dvs_u;
  assign w_rem_u  = A % w_dvs_u;

`ifdef MD_MADD_EN
  logic [63:0] w_madd;
  assign w_madd = {r_hi, r_lo} + w_prod_s;
`endif

  always_comb begin
    w_res    = w_prod_s;
    w_res_we = 1'b1;
    case (w_op)
      MD_MULTU: w_res = w_prod_u;
      MD_DIV: begin
        w_res    = {w_rem_s, w_quo_s};
        w_res_we = (B != 32'd0);
      end
      MD_DIVU: begin
        w_res    = {w_rem_u, w_quo_u};
        w_res_we = (B != 32'd0);
      end
`ifdef MD_MADD_EN
      MD_MADD: w_res = w_madd;
`endif
      default: w_res = w_prod_s;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset)
      r_state <= MD_IDLE;
    else
      r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      MD_IDLE: if (w_accept) w_state_nxt = MD_BUSY;
      MD_BUSY: if (w_done)   w_state_nxt = MD_IDLE;
      default: w_state_nxt = MD_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = (r_state == MD_BUSY);
  end

  always_ff @(posedge clk) begin
    if (reset)
      r_cnt <= '0;
    else if (w_accept)
      r_cnt <= w_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
    else if ((r_state == MD_BUSY) && !w_done)
      r_cnt <= r_cnt - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_res    <= w_res;
      r_res_we <= w_res_we;
    end
  end

  // Commit stage: HI/LO change only at completion or on an idle mthi/mtlo
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_done) begin
      if (r_res_we) begin
        r_hi <= r_res[63:32];
        r_lo <= r_res[31:0];
      end
    end else if (w_idle_start && (w_op == MD_MTHI)) begin
      r_hi <= A;
    end else if (w_idle_start && (w_op == MD_MTLO)) begin
      r_lo <= A;
    end
  end

  assign HI = r_hi;
  assign LO = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit (default latencies 5/10).
module tb_md_unit;

  logic        clk;
  logic        reset;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  MDOp;
  logic        start;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks   = 0;
  int failures = 0;
  int n;

  md_unit dut (
    .clk   (clk),
    .reset (reset),
    .A     (A),
    .B     (B),
    .MDOp  (MDOp),
    .start (start),
    .busy  (busy),
    .HI    (HI),
    .LO    (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    MDOp  = op;
    A     = a;
    B     = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    MDOp  = 3'd0;
  endtask

  // Counts edges until busy falls; HI/LO must hold their old values meanwhile.
  task automatic wait_done(output int cnt, input logic [31:0] hold_hi, input logic [31:0] hold_lo);
    cnt = 0;
    while (busy === 1'b1 && cnt < 200) begin
      chk("hold_hi", HI, hold_hi);
      chk("hold_lo", LO, hold_lo);
      tick();
      cnt++;
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    A     = '0;
    B     = '0;
    MDOp  = 3'd0;

    // Reset
    tick();
    tick();
    reset = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);

    // mult -1 * 2
    issue(3'd1, 32'hFFFF_FFFF, 32'd2);
    chk("mult_busy", {31'd0, busy}, 32'd1);
    wait_done(n, 32'd0, 32'd0);
    chk("mult_lat", n, 32'd5);
    chk("mult_hi", HI, 32'hFFFF_FFFF);
    chk("mult_lo", LO, 32'hFFFF_FFFE);

    // multu, back-to-back issue in the cycle after commit
    issue(3'd2, 32'hFFFF_FFFF, 32'd2);
    wait_done(n, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    chk("multu_lat", n, 32'd5);
    chk("multu_hi", HI, 32'h0000_0001);
    chk("multu_lo", LO, 32'hFFFF_FFFE);

    // div -7 / 2
    issue(3'd3, 32'hFFFF_FFF9, 32'd2);
    wait_done(n, 32'h0000_0001, 32'hFFFF_FFFE);
    chk("div_lat", n, 32'd10);
    chk("div_hi", HI, 32'hFFFF_FFFF);
    chk("div_lo", LO, 32'hFFFF_FFFD);

    // divu by zero: full latency, HI/LO unchanged
    issue(3'd4, 32'd7, 32'd0);
    wait_done(n, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    chk("divz_lat", n, 32'd10);
    chk("divz_hi", HI, 32'hFFFF_FFFF);
    chk("divz_lo", LO, 32'hFFFF_FFFD);

    // div 7 / -2: quotient -3, remainder +1
    issue(3'd3, 32'd7, 32'hFFFF_FFFE);
    wait_done(n, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    chk("div2_hi", HI, 32'h0000_0001);
    chk("div2_lo", LO, 32'hFFFF_FFFD);

    // signed overflow
    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(n, 32'h0000_0001, 32'hFFFF_FFFD);
    chk("ovf_hi", HI, 32'h0000_0000);
    chk("ovf_lo", LO, 32'h8000_0000);

    // divu with the same bit patterns is a plain unsigned divide
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(n, 32'h0000_0000, 32'h8000_0000);
    chk("divu_hi", HI, 32'h8000_0000);
    chk("divu_lo", LO, 32'h0000_0000);

    // mthi while busy is ignored; div 100 / 7 commits HI=2, LO=14
    issue(3'd3, 32'd100, 32'd7);
    issue(3'd5, 32'h1234_5678, 32'd0);
    chk("ign_busy", {31'd0, busy}, 32'd1);
    wait_done(n, 32'h8000_0000, 32'h0000_0000);
    chk("ign_lat", n + 1, 32'd10);
    chk("ign_hi", HI, 32'h0000_0002);
    chk("ign_lo", LO, 32'h0000_000E);

    // mthi / mtlo when idle
    issue(3'd5, 32'h1234_5678, 32'd0);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    chk("mthi_hi", HI, 32'h1234_5678);
    chk("mthi_lo", LO, 32'h0000_000E);
    issue(3'd6, 32'hCAFE_F00D, 32'd0);
    chk("mtlo_busy", {31'd0, busy}, 32'd0);
    chk("mtlo_hi", HI, 32'h1234_5678);
    chk("mtlo_lo", LO, 32'hCAFE_F00D);

    // MDOp=0 with start is ignored
    issue(3'd0, 32'hDEAD_BEEF, 32'd3);
    chk("nop_busy", {31'd0, busy}, 32'd0);
    chk("nop_hi", HI, 32'h1234_5678);
    chk("nop_lo", LO, 32'hCAFE_F00D);

    // Reset in the middle of a div
    issue(3'd3, 32'd100, 32'd7);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_hi", HI, 32'd0);
    chk("midrst_lo", LO, 32'd0);
    repeat (10) tick();
    chk("midrst_idle", {31'd0, busy}, 32'd0);
    chk("midrst_hi2", HI, 32'd0);

    // mult 3 * -4 after the aborted op
    issue(3'd1, 32'd3, 32'hFFFF_FFFC);
    wait_done(n, 32'd0, 32'd0);
    chk("post_lat", n, 32'd5);
    chk("post_hi", HI, 32'hFFFF_FFFF);
    chk("post_lo", LO, 32'hFFFF_FFF4);

    // reset and start on the same edge: reset wins
    reset = 1'b1;
    issue(3'd5, 32'hAAAA_5555, 32'd0);
    reset = 1'b0;
    chk("rs_hi", HI, 32'd0);
    chk("rs_busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;
    issue(3'd1, 32'd3, 32'd3);
    reset = 1'b0;
    chk("rs_mult_busy", {31'd0, busy}, 32'd0);

    // madd
    issue(3'd5, 32'd0, 32'd0);
    issue(3'd6, 32'hFFFF_FFFF, 32'd0);
    issue(3'd7, 32'd1, 32'd1);
`ifdef MD_MADD_EN
    chk("madd_busy", {31'd0, busy}, 32'd1);
    wait_done(n, 32'd0, 32'hFFFF_FFFF);
    chk("madd_lat", n, 32'd5);
    chk("madd_hi", HI, 32'h0000_0001);
    chk("madd_lo", LO, 32'h0000_0000);
`else
    chk("madd_busy", {31'd0, busy}, 32'd0);
    chk("madd_hi", HI, 32'h0000_0000);
    chk("madd_lo", LO, 32'hFFFF_FFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
